// File: rtl/mips_mem_arbiter.sv
// Arbitrates the fetch (I) and memory-stage (D) ports onto one fixed-latency single-port memory.
// Optional macro MIPS_MEM_ARB_FAIR_EN: alternate the winner on a tie instead of D-over-I priority.
module mips_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic [1:0]        ctrl,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic [DATA_W-1:0] iRData,
  output logic              iValid,
  output logic              iStall,
  input  logic              dReq,
  input  logic              dWrite,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWData,
  output logic [DATA_W-1:0] dRData,
  output logic              dValid,
  output logic              dStall,
  output logic              memEn,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  logic clk;
  logic rst;
  assign clk = ctrl[0];
  assign rst = ctrl[1];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              acc_we_q, acc_we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_valid_q, i_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              i_elig, d_elig, grant_i, grant_d;

  // A port is stale during its own completion cycle and may not be regranted then.
  assign i_elig = iReq & ~i_valid_q;
  assign d_elig = dReq & ~d_valid_q;

`ifdef MIPS_MEM_ARB_FAIR_EN
  logic last_d_q, last_d_d;  // 1 = D was the most recent grant
  assign grant_d = d_elig & (~i_elig | ~last_d_q);
`else
  assign grant_d = d_elig;
`endif
  assign grant_i = i_elig & ~grant_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_we_d    = acc_we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
`ifdef MIPS_MEM_ARB_FAIR_EN
    last_d_d    = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = BUSY_D;
          cnt_d       = 4'(LATENCY);
          acc_we_d    = dWrite;
          mem_en_d    = 1'b1;
          mem_we_d    = dWrite;
          mem_addr_d  = dAddr;
          mem_wdata_d = dWData;
`ifdef MIPS_MEM_ARB_FAIR_EN
          last_d_d    = 1'b1;
`endif
        end else if (grant_i) begin
          state_d    = BUSY_I;
          cnt_d      = 4'(LATENCY);
          acc_we_d   = 1'b0;
          mem_en_d   = 1'b1;
          mem_addr_d = iAddr;
`ifdef MIPS_MEM_ARB_FAIR_EN
          last_d_d   = 1'b0;
`endif
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          if (state_q == BUSY_I) begin
            i_valid_d = 1'b1;
            i_rdata_d = memRData;
          end else begin
            d_valid_d = 1'b1;
            if (!acc_we_q) d_rdata_d = memRData;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_we_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
`ifdef MIPS_MEM_ARB_FAIR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_we_q    <= acc_we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
`ifdef MIPS_MEM_ARB_FAIR_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign iRData   = i_rdata_q;
  assign iValid   = i_valid_q;
  assign iStall   = iReq & ~i_valid_q;
  assign dRData   = d_rdata_q;
  assign dValid   = d_valid_q;
  assign dStall   = dReq & ~d_valid_q;
  assign memEn    = mem_en_q;
  assign memWe    = mem_we_q;
  assign memAddr  = mem_addr_q;
  assign memWData = mem_wdata_q;

endmodule
